cdb_arbiter: RTL and testbench

- Schedules the single common data bus (CDB) among the execution-side requesters: ALU RS/FU, load-store RS/FU and branch RS/FU.
- Each cycle it grants one requester using round-robin, with a bounded-priority override for one designated requester.
- It registers the winner's ROB tag and result onto the CDB. The ROB and all reservation stations snoop this bus.
- It sits between the functional-unit result ports and the ROB/RS wakeup logic, downstream of the decoder's dispatch.

---
 rtl/cdb_arbiter.sv | 166 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Common data bus arbiter. Grants one execution-side requester
//               per cycle (round-robin with a bounded-priority override for
//               PRIO_IDX) and registers the winner's ROB tag/result onto the
//               CDB with one cycle of latency.
//               Optional macro CDB_ARB_STATS_EN adds internal grant, stall and
//               idle counters (hierarchical access only, no extra ports).
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int TAG_BITS = 4,
  parameter int DATA_W   = 32,
  parameter int PRIO_IDX = 2,
  parameter int PRIO_MAX = 2
) (
  input  logic                         clk,
  input  logic                         rst,        // asynchronous, active-low
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*TAG_BITS-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         cdb_valid,
  output logic [TAG_BITS-1:0]          cdb_tag,
  output logic [DATA_W-1:0]            cdb_data,
  output logic [1:0]                   cdb_src
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (PRIO_MAX > 0) ? $clog2(PRIO_MAX + 1) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W-1:0] PRIO_PTR = PTR_W'(PRIO_IDX);
  localparam logic [CNT_W-1:0] PRIO_LIM = CNT_W'(PRIO_MAX);

  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    prio_cnt_q, prio_cnt_d;
  logic                cdb_valid_q;
  logic [TAG_BITS-1:0] cdb_tag_q;
  logic [DATA_W-1:0]   cdb_data_q;
  logic [1:0]          cdb_src_q;

  logic                grant_any;
  logic                override;
  logic [PTR_W-1:0]    grant_idx;
  logic [TAG_BITS-1:0] sel_tag;
  logic [DATA_W-1:0]   sel_data;

  // Grant selection: flush suppresses everything, then override, then round-robin
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    override  = 1'b0;
    grant_idx = '0;
    if (!flush) begin
      if (req_valid[PRIO_IDX] && (prio_cnt_q < PRIO_LIM)) begin
        grant_any = 1'b1;
        override  = 1'b1;
        grant_idx = PRIO_PTR;
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          // explicit wrap so NUM_REQ need not be a power of two
          idx = int'(rr_ptr_q) + k;
          if (idx >= NUM_REQ) idx = idx - NUM_REQ;
          if (!grant_any && req_valid[idx]) begin
            grant_any = 1'b1;
            grant_idx = PTR_W'(idx);
          end
        end
      end
    end
  end

  // One-hot ready plus mux of the winner's tag/data; ready is held low in reset
  always_comb begin
    req_ready = '0;
    sel_tag   = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_any && (grant_idx == PTR_W'(i))) begin
        req_ready[i] = rst;
        sel_tag      = req_tag[i*TAG_BITS +: TAG_BITS];
        sel_data     = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state for round-robin pointer and override counter (both hold on flush)
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    prio_cnt_d = prio_cnt_q;
    if (grant_any) begin
      rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
    if (!flush) begin
      if (!req_valid[PRIO_IDX]) begin
        prio_cnt_d = '0;
      end else if (override) begin
        prio_cnt_d = (prio_cnt_q < PRIO_LIM) ? prio_cnt_q + 1'b1 : prio_cnt_q;
      end else if (grant_any) begin
        prio_cnt_d = '0;
      end
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q   <= '0;
      prio_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      prio_cnt_q <= prio_cnt_d;
    end
  end

  // CDB output register; tag/data/src hold when nothing is granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      cdb_valid_q <= grant_any;
      if (grant_any) begin
        cdb_tag_q  <= sel_tag;
        cdb_data_q <= sel_data;
        cdb_src_q  <= 2'(grant_idx);
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

`ifdef CDB_ARB_STATS_EN
  logic [31:0] grant_cnt_q [NUM_REQ];
  logic [31:0] stall_cnt_q [NUM_REQ];
  logic [31:0] idle_cnt_q;

  // Statistics: grants, stalls (valid but not granted outside flush), idle cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt_q[i] <= '0;
        stall_cnt_q[i] <= '0;
      end
      idle_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
        if (req_valid[i] && !req_ready[i] && !flush) stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
      end
      if (!grant_any) idle_cnt_q <= idle_cnt_q + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Directed self-checking bench for cdb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [2:0]  req_valid;
  logic [11:0] req_tag;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;

  int n_vec;
  int n_err;

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] t, input logic [31:0] d);
    req_tag[i*4 +: 4]   = t;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic chk_cdb(input string tag, input logic v, input logic [3:0] t,
                         input logic [31:0] d, input logic [1:0] s);
    chk({tag, ".valid"}, 64'(cdb_valid), 64'(v));
    chk({tag, ".tag"},   64'(cdb_tag),   64'(t));
    chk({tag, ".data"},  64'(cdb_data),  64'(d));
    chk({tag, ".src"},   64'(cdb_src),   64'(s));
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 3'b000;
    req_tag   = '0;
    req_data  = '0;
    #2 rst = 1'b0;

    // ---- reset with all three requesters valid, tags 1,2,3 ----
    set_req(0, 4'd1, 32'h0000_0101);
    set_req(1, 4'd2, 32'h0000_0202);
    set_req(2, 4'd3, 32'h0000_0303);
    req_valid = 3'b111;
    #1;
    chk_cdb("reset", 1'b0, 4'd0, 32'd0, 2'd0);
    chk("reset.ready", 64'(req_ready), 64'd0);
    chk("reset.rr", 64'(dut.rr_ptr_q), 64'd0);
    chk("reset.prio", 64'(dut.prio_cnt_q), 64'd0);

    tick();
    rst = 1'b1;
    #1;
    chk("ovr1.ready", 64'(req_ready), 64'b100);
    tick();
    chk_cdb("ovr1.cdb", 1'b1, 4'd3, 32'h0303, 2'd2);
    chk("ovr1.prio", 64'(dut.prio_cnt_q), 64'd1);
    chk("ovr2.ready", 64'(req_ready), 64'b100);
    tick();
    chk_cdb("ovr2.cdb", 1'b1, 4'd3, 32'h0303, 2'd2);
    chk("ovr2.prio", 64'(dut.prio_cnt_q), 64'd2);
    chk("rr_alu.ready", 64'(req_ready), 64'b001);
    tick();
    chk_cdb("rr_alu.cdb", 1'b1, 4'd1, 32'h0101, 2'd0);
    chk("rr_alu.rr", 64'(dut.rr_ptr_q), 64'd1);
    chk("rr_alu.prio", 64'(dut.prio_cnt_q), 64'd0);
    chk("ovr3.ready", 64'(req_ready), 64'b100);
    tick();
    chk_cdb("ovr3.cdb", 1'b1, 4'd3, 32'h0303, 2'd2);
    chk("ovr3.rr", 64'(dut.rr_ptr_q), 64'd0);

    // ---- ALU and LDST only, fresh tag after each grant ----
    req_valid = 3'b011;
    set_req(0, 4'd4, 32'h0000_0404);
    set_req(1, 4'd6, 32'h0000_0606);
    #1;
    chk("alt0.ready", 64'(req_ready), 64'b001);
    tick();
    chk_cdb("alt0.cdb", 1'b1, 4'd4, 32'h0404, 2'd0);
    set_req(0, 4'd7, 32'h0000_0707);
    #1;
    chk("alt1.ready", 64'(req_ready), 64'b010);
    tick();
    chk_cdb("alt1.cdb", 1'b1, 4'd6, 32'h0606, 2'd1);
    chk("alt1.rr", 64'(dut.rr_ptr_q), 64'd2);
    set_req(1, 4'd8, 32'h0000_0808);
    #1;
    // rr_ptr=2 with BR idle: search wraps to ALU
    chk("wrap.ready", 64'(req_ready), 64'b001);
    tick();
    chk_cdb("wrap.cdb", 1'b1, 4'd7, 32'h0707, 2'd0);
    chk("wrap.rr", 64'(dut.rr_ptr_q), 64'd1);
    chk("alt3.ready", 64'(req_ready), 64'b010);
    tick();
    chk_cdb("alt3.cdb", 1'b1, 4'd8, 32'h0808, 2'd1);

    // ---- single LDST requester ----
    req_valid = 3'b010;
    set_req(1, 4'd5, 32'hDEAD_BEEF);
    #1;
    chk("single.ready", 64'(req_ready), 64'b010);
    tick();
    chk_cdb("single.cdb", 1'b1, 4'd5, 32'hDEAD_BEEF, 2'd1);
    req_valid = 3'b000;
    #1;
    chk("idle.ready", 64'(req_ready), 64'd0);
    tick();
    chk_cdb("idle.cdb", 1'b0, 4'd5, 32'hDEAD_BEEF, 2'd1);
    chk("idle.rr", 64'(dut.rr_ptr_q), 64'd2);
    chk("idle.prio", 64'(dut.prio_cnt_q), 64'd0);

    // ---- flush with all valid ----
    set_req(0, 4'd9,  32'h0000_0909);
    set_req(1, 4'd10, 32'h0000_0A0A);
    set_req(2, 4'd11, 32'h0000_0B0B);
    req_valid = 3'b111;
    flush     = 1'b1;
    #1;
    chk("flush.ready", 64'(req_ready), 64'd0);
    tick();
    chk("flush.cdbv", 64'(cdb_valid), 64'd0);
    chk("flush.rr", 64'(dut.rr_ptr_q), 64'd2);
    chk("flush.prio", 64'(dut.prio_cnt_q), 64'd0);
    flush = 1'b0;
    #1;
    chk("postflush.ready", 64'(req_ready), 64'b100);
    tick();
    chk_cdb("postflush.cdb", 1'b1, 4'd11, 32'h0B0B, 2'd2);
    chk("postflush.prio", 64'(dut.prio_cnt_q), 64'd1);

    // ---- asynchronous reset while cdb_valid=1 ----
    rst = 1'b0;
    #1;
    chk("asyncrst.cdbv", 64'(cdb_valid), 64'd0);
    chk("asyncrst.ready", 64'(req_ready), 64'd0);
    chk("asyncrst.prio", 64'(dut.prio_cnt_q), 64'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("release.rr", 64'(dut.rr_ptr_q), 64'd0);
    chk("release.ready", 64'(req_ready), 64'b100);
    tick();
    chk_cdb("release.cdb", 1'b1, 4'd11, 32'h0B0B, 2'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
